// File: rtl/arbitro_pkg.sv
// Shared types and defaults for the two-VC weighted round-robin arbiter.
package arbitro_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERV0 = 2'd1,
      SERV1 = 2'd2
   } arb_state_t;

   localparam int DATA_W_DEF   = 6;
   localparam int DEST_BIT_DEF = 4;

   localparam logic VC0_IDX = 1'b0;
   localparam logic VC1_IDX = 1'b1;

endpackage

// File: rtl/arbitro_wrr_sel.sv
// Combinational grant selection: eligibility, weighted turn/counter and its next value.
module arbitro_wrr_sel
   import arbitro_pkg::*;
#(
   parameter int W0    = 4,
   parameter int W1    = 1,
   parameter int CNT_W = 3
) (
   input  logic             i_vc0_empty,
   input  logic             i_vc1_empty,
   input  logic             i_vc0_dest,
   input  logic             i_vc1_dest,
   input  logic             i_d0_pause,
   input  logic             i_d1_pause,
   input  logic             i_turn,
   input  logic [CNT_W-1:0] i_cnt,
   output logic             o_grant_vld,
   output logic             o_grant_vc,
   output logic             o_turn_nxt,
   output logic [CNT_W-1:0] o_cnt_nxt
);

   logic             w_elig0;
   logic             w_elig1;
   logic [CNT_W-1:0] w_base;
   logic [CNT_W-1:0] w_n;
   logic [CNT_W-1:0] w_weight;

   // A VC is eligible only if its head word's destination is not paused (head-of-line).
   assign w_elig0 = !i_vc0_empty && !(i_vc0_dest ? i_d1_pause : i_d0_pause);
   assign w_elig1 = !i_vc1_empty && !(i_vc1_dest ? i_d1_pause : i_d0_pause);

   assign o_grant_vld = w_elig0 | w_elig1;
   assign o_grant_vc  = (w_elig0 && w_elig1) ? i_turn : w_elig1;

   assign w_base   = (o_grant_vc == i_turn) ? i_cnt : '0;
   assign w_n      = w_base + CNT_W'(1);
   assign w_weight = (o_grant_vc == VC1_IDX) ? CNT_W'(W1) : CNT_W'(W0);

   always_comb begin
      o_turn_nxt = i_turn;
      o_cnt_nxt  = i_cnt;
      if (o_grant_vld) begin
         if (w_n == w_weight) begin
            o_turn_nxt = ~o_grant_vc;
            o_cnt_nxt  = '0;
         end else begin
            o_turn_nxt = o_grant_vc;
            o_cnt_nxt  = w_n;
         end
      end
   end

endmodule

// File: rtl/arbitro_vc_wrr.sv
// Weighted round-robin drain of VC0/VC1 into D0/D1, routed by a destination bit, latency 1.
module arbitro_vc_wrr
   import arbitro_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int DEST_BIT = DEST_BIT_DEF,
   parameter int W0       = 4,
   parameter int W1       = 1,
   parameter int CNT_W    = 3
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [DATA_W-1:0] VC0,
   input  logic [DATA_W-1:0] VC1,
   input  logic              VC0_empty,
   input  logic              VC1_empty,
   input  logic              D0_pause,
   input  logic              D1_pause,
   output logic              VC0_pop,
   output logic              VC1_pop,
   output logic [DATA_W-1:0] D0,
   output logic [DATA_W-1:0] D1,
   output logic              D0_push,
   output logic              D1_push,
   output logic              arb_idle,
   output logic [1:0]        o_dbg_state
);

   arb_state_t        r_state;
   logic              r_turn;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_d0;
   logic [DATA_W-1:0] r_d1;
   logic              r_d0_push;
   logic              r_d1_push;

   logic              w_grant_vld;
   logic              w_grant_vc;
   logic              w_turn_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] w_word;

   arbitro_wrr_sel #(
      .W0    (W0),
      .W1    (W1),
      .CNT_W (CNT_W)
   ) u_sel (
      .i_vc0_empty (VC0_empty),
      .i_vc1_empty (VC1_empty),
      .i_vc0_dest  (VC0[DEST_BIT]),
      .i_vc1_dest  (VC1[DEST_BIT]),
      .i_d0_pause  (D0_pause),
      .i_d1_pause  (D1_pause),
      .i_turn      (r_turn),
      .i_cnt       (r_cnt),
      .o_grant_vld (w_grant_vld),
      .o_grant_vc  (w_grant_vc),
      .o_turn_nxt  (w_turn_nxt),
      .o_cnt_nxt   (w_cnt_nxt)
   );

   // Pops are gated by reset so an asserted reset stops draining immediately.
   assign VC0_pop = reset_L & w_grant_vld & (w_grant_vc == VC0_IDX);
   assign VC1_pop = reset_L & w_grant_vld & (w_grant_vc == VC1_IDX);
   assign w_word  = (w_grant_vc == VC1_IDX) ? VC1 : VC0;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         r_state   <= IDLE;
         r_turn    <= VC0_IDX;
         r_cnt     <= '0;
         r_d0      <= '0;
         r_d1      <= '0;
         r_d0_push <= 1'b0;
         r_d1_push <= 1'b0;
      end else begin
         r_turn    <= w_turn_nxt;
         r_cnt     <= w_cnt_nxt;
         r_d0_push <= 1'b0;
         r_d1_push <= 1'b0;
         if (w_grant_vld) begin
            r_state <= (w_grant_vc == VC1_IDX) ? SERV1 : SERV0;
            if (w_word[DEST_BIT]) begin
               r_d1      <= w_word;
               r_d1_push <= 1'b1;
            end else begin
               r_d0      <= w_word;
               r_d0_push <= 1'b1;
            end
         end else begin
            r_state <= IDLE;
         end
      end
   end

   assign D0          = r_d0;
   assign D1          = r_d1;
   assign D0_push     = r_d0_push;
   assign D1_push     = r_d1_push;
   assign arb_idle    = (r_state == IDLE);
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_arbitro_vc_wrr.sv
// Directed bench for arbitro_vc_wrr: reset, weighting, routing, pause, work-conserving, mid-burst reset.
module tb_arbitro_vc_wrr;

   logic       clk;
   logic       reset_L;
   logic [5:0] VC0;
   logic [5:0] VC1;
   logic       VC0_empty;
   logic       VC1_empty;
   logic       D0_pause;
   logic       D1_pause;
   logic       VC0_pop;
   logic       VC1_pop;
   logic [5:0] D0;
   logic [5:0] D1;
   logic       D0_push;
   logic       D1_push;
   logic       arb_idle;
   logic [1:0] o_dbg_state;

   int n_checks;
   int n_errors;
   logic [5:0] exp_q[$];

   localparam logic [5:0] W_A   = 6'h03;      // bit4=0 -> D0
   localparam logic [5:0] W_B   = 6'h05;      // bit4=0 -> D0
   localparam logic [5:0] W_TO1 = 6'b110100;  // bit4=1 -> D1
   localparam logic [5:0] W_TO0 = 6'b100101;  // bit4=0 -> D0

   arbitro_vc_wrr dut (
      .clk         (clk),
      .reset_L     (reset_L),
      .VC0         (VC0),
      .VC1         (VC1),
      .VC0_empty   (VC0_empty),
      .VC1_empty   (VC1_empty),
      .D0_pause    (D0_pause),
      .D1_pause    (D1_pause),
      .VC0_pop     (VC0_pop),
      .VC1_pop     (VC1_pop),
      .D0          (D0),
      .D1          (D1),
      .D0_push     (D0_push),
      .D1_push     (D1_push),
      .arb_idle    (arb_idle),
      .o_dbg_state (o_dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: sim time exceeded, actual=timeout required=finish");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", tag, obs, exp);
      end
   endtask

   // drive inputs at negedge, settle combinational pops
   task automatic drive(input logic [5:0] v0, input logic [5:0] v1, input logic e0,
                        input logic e1, input logic p0, input logic p1);
      @(negedge clk);
      VC0 = v0; VC1 = v1; VC0_empty = e0; VC1_empty = e1; D0_pause = p0; D1_pause = p1;
      #1;
   endtask

   task automatic check_pops(input string tag, input logic e_p0, input logic e_p1);
      check_val({tag, "_vc0_pop"}, {31'd0, VC0_pop}, {31'd0, e_p0});
      check_val({tag, "_vc1_pop"}, {31'd0, VC1_pop}, {31'd0, e_p1});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [5:0] e_d0, input logic [5:0] e_d1,
                            input logic e_push0, input logic e_push1, input logic e_idle);
      check_val({tag, "_d0"}, {26'd0, D0}, {26'd0, e_d0});
      check_val({tag, "_d1"}, {26'd0, D1}, {26'd0, e_d1});
      check_val({tag, "_d0_push"}, {31'd0, D0_push}, {31'd0, e_push0});
      check_val({tag, "_d1_push"}, {31'd0, D1_push}, {31'd0, e_push1});
      check_val({tag, "_idle"}, {31'd0, arb_idle}, {31'd0, e_idle});
   endtask

   initial begin
      logic [9:0] pat;
      logic [4:0] pat5;
      logic [5:0] exp_w;
      n_checks = 0;
      n_errors = 0;
      reset_L = 1'b0;
      VC0 = W_A; VC1 = W_B; VC0_empty = 1'b0; VC1_empty = 1'b0;
      D0_pause = 1'b0; D1_pause = 1'b0;

      // reset held for 2 clocks with non-empty VCs
      tick;
      tick;
      check_pops("rst", 1'b0, 1'b0);
      check_out("rst", 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      check_val("rst_state", {30'd0, o_dbg_state}, 32'd0);

      // weighting: 4x VC0 then 1x VC1, repeating; bit i set = VC1 granted in cycle i
      @(negedge clk);
      reset_L = 1'b1;
      pat = 10'b10000_10000;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) drive(W_A, W_B, 1'b0, 1'b0, 1'b0, 1'b0);
         else #1;
         check_pops($sformatf("wt%0d", i), !pat[i], pat[i]);
         exp_q.push_back(pat[i] ? W_B : W_A);
         tick;
         exp_w = exp_q.pop_front();
         check_out($sformatf("wt%0d", i), exp_w, 6'd0, 1'b1, 1'b0, 1'b0);
         check_val($sformatf("wt%0d_state", i), {30'd0, o_dbg_state}, pat[i] ? 32'd2 : 32'd1);
      end

      // routing by bit4 (turn=VC0, cnt=0 here)
      drive(W_TO1, W_B, 1'b0, 1'b1, 1'b0, 1'b0);
      check_pops("rt1", 1'b1, 1'b0);
      tick;
      check_out("rt1", W_B, W_TO1, 1'b0, 1'b1, 1'b0);
      drive(W_TO0, W_B, 1'b0, 1'b1, 1'b0, 1'b0);
      check_pops("rt0", 1'b1, 1'b0);
      tick;
      check_out("rt0", W_TO0, W_TO1, 1'b1, 1'b0, 1'b0);

      // both empty: no grant, outputs hold, idle next cycle
      drive(W_A, W_B, 1'b1, 1'b1, 1'b0, 1'b0);
      check_pops("idle", 1'b0, 1'b0);
      tick;
      check_out("idle", W_TO0, W_TO1, 1'b0, 1'b0, 1'b1);

      // D1 paused: VC0 head blocked, VC1 (to D0) drains; VC1 grant resets cnt, turn->VC0
      for (int i = 0; i < 3; i++) begin
         drive(W_TO1, W_TO0, 1'b0, 1'b0, 1'b0, 1'b1);
         check_pops($sformatf("pause%0d", i), 1'b0, 1'b1);
         tick;
         check_out($sformatf("pause%0d", i), W_TO0, W_TO1, 1'b1, 1'b0, 1'b0);
      end
      drive(W_TO1, W_TO0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_pops("unpause", 1'b1, 1'b0);
      tick;
      check_out("unpause", W_TO0, W_TO1, 1'b0, 1'b1, 1'b0);

      // work-conserving: bring VC0 to cnt=2, then VC0 empties
      drive(W_A, W_B, 1'b0, 1'b0, 1'b0, 1'b0);
      check_pops("wc_pre", 1'b1, 1'b0);
      tick;
      check_out("wc_pre", W_A, W_TO1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         drive(W_A, W_B, 1'b1, 1'b0, 1'b0, 1'b0);
         check_pops($sformatf("wc%0d", i), 1'b0, 1'b1);
         tick;
         check_out($sformatf("wc%0d", i), W_B, W_TO1, 1'b1, 1'b0, 1'b0);
      end
      pat5 = 5'b10000;
      for (int i = 0; i < 5; i++) begin
         drive(W_A, W_B, 1'b0, 1'b0, 1'b0, 1'b0);
         check_pops($sformatf("refill%0d", i), !pat5[i], pat5[i]);
         tick;
         check_out($sformatf("refill%0d", i), pat5[i] ? W_B : W_A, W_TO1, 1'b1, 1'b0, 1'b0);
      end

      // mid-burst reset: 4 VC0 grants leave turn on VC1, then reset between edges
      for (int i = 0; i < 4; i++) begin
         drive(W_A, W_B, 1'b0, 1'b0, 1'b0, 1'b0);
         check_pops($sformatf("mb%0d", i), 1'b1, 1'b0);
         tick;
      end
      check_pops("mb_turn1", 1'b0, 1'b1);
      #1;
      reset_L = 1'b0;
      #1;
      check_pops("mbrst", 1'b0, 1'b0);
      check_out("mbrst", 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      reset_L = 1'b1;
      #1;
      check_pops("mbrel", 1'b1, 1'b0);
      tick;
      check_out("mbrel", W_A, 6'd0, 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
